// File: rtl/collision_pkg.sv
// Shared geometry defaults, side-flag bit positions and scan FSM states
// for the sprite-vs-tile collision scanner.
package collision_pkg;

  // Default sprite/tile geometry in pixels
  localparam int DEF_SPR_W    = 47;
  localparam int DEF_SPR_H    = 41;
  localparam int DEF_TILE_W   = 25;
  localparam int DEF_TILE_H   = 24;
  localparam int DEF_INSET_L  = 12;
  localparam int DEF_INSET_R  = 17;
  localparam int DEF_SIDE_OFS = 2;
  localparam int DEF_FOOT     = 4;

  // Bit position of each side inside the 4-bit collision vector
  typedef enum logic [1:0] {
    DOWN  = 2'd0,
    UP    = 2'd1,
    RIGHT = 2'd2,
    LEFT  = 2'd3
  } side_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } scan_state_e;

endpackage

// File: rtl/collision_box_cmp.sv
// Combinational overlap test of one sprite box against one tile box,
// producing the down/up/right/left side flags. All arithmetic is done one
// bit wider than the coordinates so sums near the screen edge never wrap.
module collision_box_cmp
  import collision_pkg::*;
#(
  parameter int XW       = 10,
  parameter int YW       = 9,
  parameter int SPR_W    = DEF_SPR_W,
  parameter int SPR_H    = DEF_SPR_H,
  parameter int TILE_W   = DEF_TILE_W,
  parameter int TILE_H   = DEF_TILE_H,
  parameter int INSET_L  = DEF_INSET_L,
  parameter int INSET_R  = DEF_INSET_R,
  parameter int SIDE_OFS = DEF_SIDE_OFS,
  parameter int FOOT     = DEF_FOOT
) (
  input  logic [XW-1:0] x_sprite,
  input  logic [YW-1:0] y_sprite,
  input  logic [XW-1:0] tile_x,
  input  logic [YW-1:0] tile_y,
  output logic [3:0]    flags
);

  localparam logic [XW:0] K_SPR_W    = SPR_W[XW:0];
  localparam logic [XW:0] K_TILE_W   = TILE_W[XW:0];
  localparam logic [XW:0] K_INSET_L  = INSET_L[XW:0];
  localparam logic [XW:0] K_INSET_R  = INSET_R[XW:0];
  localparam logic [XW:0] K_SIDE_X   = SIDE_OFS[XW:0];
  localparam logic [YW:0] K_SPR_H    = SPR_H[YW:0];
  localparam logic [YW:0] K_TILE_H   = TILE_H[YW:0];
  localparam logic [YW:0] K_FOOT     = FOOT[YW:0];
  localparam logic [YW:0] K_SIDE_Y   = SIDE_OFS[YW:0];
  localparam logic [YW:0] K_ONE_Y    = 1;

  logic [XW:0] xs, tx, spr_r, spr_side, tile_r;
  logic [YW:0] ys, ty, spr_b, tile_b;
  logic        h_ovl, v_span;

  assign xs       = {1'b0, x_sprite};
  assign tx       = {1'b0, tile_x};
  assign ys       = {1'b0, y_sprite};
  assign ty       = {1'b0, tile_y};
  assign spr_r    = xs + K_SPR_W - K_INSET_R;
  assign spr_side = xs + K_SPR_W - K_SIDE_X;
  assign tile_r   = tx + K_TILE_W;
  assign spr_b    = ys + K_SPR_H;
  assign tile_b   = ty + K_TILE_H;

  assign h_ovl  = (spr_r > tx) && ((xs + K_INSET_L) < tile_r);
  assign v_span = ((ys + K_SIDE_Y) <= tile_b) && ((spr_b - K_ONE_Y) >= ty);

  // Evaluate each side probe against the current tile
  always_comb begin
    flags        = '0;
    flags[DOWN]  = h_ovl && (spr_b >= ty) && ((spr_b + K_FOOT) <= tile_b);
    flags[UP]    = h_ovl && (ys >= ty) && (ys <= tile_b);
    flags[RIGHT] = v_span && (spr_side >= tx) && (spr_side <= tile_r);
    flags[LEFT]  = v_span && (xs >= tx) && (xs <= tile_r);
  end

endmodule

// File: rtl/collision_scan.sv
// Collision scanner: walks a tile table through a one-cycle-latency read
// port with a single shared box comparator, OR-accumulating side flags and
// counting hit tiles, then publishes the result with a one-cycle done.
// Optional feature macro: COLLISION_SCAN_HIT_INDEX_EN adds ground_idx /
// ground_vld reporting the lowest tile index whose down flag fired.
module collision_scan
  import collision_pkg::*;
#(
  parameter int N_TILES  = 16,
  parameter int XW       = 10,
  parameter int YW       = 9,
  parameter int SPR_W    = DEF_SPR_W,
  parameter int SPR_H    = DEF_SPR_H,
  parameter int TILE_W   = DEF_TILE_W,
  parameter int TILE_H   = DEF_TILE_H,
  parameter int INSET_L  = DEF_INSET_L,
  parameter int INSET_R  = DEF_INSET_R,
  parameter int SIDE_OFS = DEF_SIDE_OFS,
  parameter int FOOT     = DEF_FOOT,
  localparam int AW      = (N_TILES > 1) ? $clog2(N_TILES) : 1,
  localparam int CW      = $clog2(N_TILES + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [XW-1:0] x_sprite,
  input  logic [YW-1:0] y_sprite,
  output logic [AW-1:0] tile_addr,
  input  logic [XW-1:0] tile_x,
  input  logic [YW-1:0] tile_y,
  input  logic          tile_en,
  output logic          busy,
  output logic          done,
  output logic [3:0]    is_collision,
`ifdef COLLISION_SCAN_HIT_INDEX_EN
  output logic [AW-1:0] ground_idx,
  output logic          ground_vld,
`endif
  output logic [CW-1:0] hit_count
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(N_TILES - 1);

  scan_state_e   state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          vld_q, vld_d;
  logic [XW-1:0] xs_q, xs_d;
  logic [YW-1:0] ys_q, ys_d;
  logic [3:0]    sh_flags_q, sh_flags_d;
  logic [CW-1:0] sh_cnt_q, sh_cnt_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [3:0]    coll_q, coll_d;
  logic [CW-1:0] hit_q, hit_d;
  logic [3:0]    cmp_flags;
`ifdef COLLISION_SCAN_HIT_INDEX_EN
  logic [AW-1:0] idx_q, idx_d;
  logic [AW-1:0] sh_gidx_q, sh_gidx_d;
  logic          sh_gvld_q, sh_gvld_d;
  logic [AW-1:0] gidx_q, gidx_d;
  logic          gvld_q, gvld_d;
`endif

  collision_box_cmp #(
    .XW(XW), .YW(YW), .SPR_W(SPR_W), .SPR_H(SPR_H),
    .TILE_W(TILE_W), .TILE_H(TILE_H), .INSET_L(INSET_L),
    .INSET_R(INSET_R), .SIDE_OFS(SIDE_OFS), .FOOT(FOOT)
  ) u_cmp (
    .x_sprite (xs_q),
    .y_sprite (ys_q),
    .tile_x   (tile_x),
    .tile_y   (tile_y),
    .flags    (cmp_flags)
  );

  // Next-state logic: FSM sequencing, address walk and shadow accumulation
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    state_d    = state_q;
    addr_d     = addr_q;
    vld_d      = (state_q == S_ISSUE);
    xs_d       = xs_q;
    ys_d       = ys_q;
    sh_flags_d = sh_flags_q;
    sh_cnt_d   = sh_cnt_q;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    coll_d     = coll_q;
    hit_d      = hit_q;
`ifdef COLLISION_SCAN_HIT_INDEX_EN
    idx_d      = addr_q;
    sh_gidx_d  = sh_gidx_q;
    sh_gvld_d  = sh_gvld_q;
    gidx_d     = gidx_q;
    gvld_d     = gvld_q;
`endif

    // Check stage: read data for the address issued last cycle is present now
    if (vld_q && tile_en) begin
      sh_flags_d = sh_flags_q | cmp_flags;
      if (|cmp_flags) sh_cnt_d = sh_cnt_q + CW'(1);
`ifdef COLLISION_SCAN_HIT_INDEX_EN
      if (cmp_flags[DOWN] && !sh_gvld_q) begin
        sh_gidx_d = idx_q;
        sh_gvld_d = 1'b1;
      end
`endif
    end

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_ISSUE;
          addr_d     = '0;
          xs_d       = x_sprite;
          ys_d       = y_sprite;
          sh_flags_d = '0;
          sh_cnt_d   = '0;
          busy_d     = 1'b1;
`ifdef COLLISION_SCAN_HIT_INDEX_EN
          sh_gidx_d  = '0;
          sh_gvld_d  = 1'b0;
`endif
        end
      end
      S_ISSUE: begin
        busy_d = 1'b1;
        if (addr_q == LAST_ADDR) begin
          state_d = S_DRAIN;
          addr_d  = '0;
        end else begin
          addr_d  = addr_q + AW'(1);
        end
      end
      S_DRAIN: begin
        // Publish including the final check happening this cycle
        state_d = S_DONE;
        done_d  = 1'b1;
        coll_d  = sh_flags_d;
        hit_d   = sh_cnt_d;
`ifdef COLLISION_SCAN_HIT_INDEX_EN
        gidx_d  = sh_gidx_d;
        gvld_d  = sh_gvld_d;
`endif
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register with synchronous reset; all outputs come straight from flops
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      state_q    <= S_IDLE;
      addr_q     <= '0;
      vld_q      <= 1'b0;
      xs_q       <= '0;
      ys_q       <= '0;
      sh_flags_q <= '0;
      sh_cnt_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      coll_q     <= '0;
      hit_q      <= '0;
`ifdef COLLISION_SCAN_HIT_INDEX_EN
      idx_q      <= '0;
      sh_gidx_q  <= '0;
      sh_gvld_q  <= 1'b0;
      gidx_q     <= '0;
      gvld_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      vld_q      <= vld_d;
      xs_q       <= xs_d;
      ys_q       <= ys_d;
      sh_flags_q <= sh_flags_d;
      sh_cnt_q   <= sh_cnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      coll_q     <= coll_d;
      hit_q      <= hit_d;
`ifdef COLLISION_SCAN_HIT_INDEX_EN
      idx_q      <= idx_d;
      sh_gidx_q  <= sh_gidx_d;
      sh_gvld_q  <= sh_gvld_d;
      gidx_q     <= gidx_d;
      gvld_q     <= gvld_d;
`endif
    end
  end

  assign tile_addr    = addr_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign is_collision = coll_q;
  assign hit_count    = hit_q;
`ifdef COLLISION_SCAN_HIT_INDEX_EN
  assign ground_idx   = gidx_q;
  assign ground_vld   = gvld_q;
`endif

endmodule

// File: tb/tb_collision_scan.sv
// Scoreboard bench for collision_scan: a stimulus process loads a tile
// table, issues scans and pushes model results; a monitor pops and compares
// on every done pulse and tracks busy/tile_addr against the expected window.
module tb_collision_scan;
  import collision_pkg::*;

  localparam int N  = 16;
  localparam int XW = 10;
  localparam int YW = 9;
  localparam int AW = $clog2(N);
  localparam int CW = $clog2(N + 1);

  typedef struct {
    logic [3:0] flags;
    int         cnt;
    int         cyc;
    int         gidx;
    bit         gvld;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [XW-1:0] x_sprite = '0;
  logic [YW-1:0] y_sprite = '0;
  logic [AW-1:0] tile_addr;
  logic [XW-1:0] tile_x = '0;
  logic [YW-1:0] tile_y = '0;
  logic          tile_en = 1'b0;
  logic          busy, done;
  logic [3:0]    is_collision;
  logic [CW-1:0] hit_count;
`ifdef COLLISION_SCAN_HIT_INDEX_EN
  logic [AW-1:0] ground_idx;
  logic          ground_vld;
`endif

  int tx_mem [N];
  int ty_mem [N];
  bit en_mem [N];

  exp_t sb[$];
  int   cyc = 0;
  int   n_pass = 0;
  int   n_total = 0;
  int   busy_lo = 0, busy_hi = -1;
  int   addr_lo = 0, addr_hi = -1;
  int   last_done = -1, prev_done = -1;

  collision_scan #(.N_TILES(N), .XW(XW), .YW(YW)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .x_sprite     (x_sprite),
    .y_sprite     (y_sprite),
    .tile_addr    (tile_addr),
    .tile_x       (tile_x),
    .tile_y       (tile_y),
    .tile_en      (tile_en),
    .busy         (busy),
    .done         (done),
    .is_collision (is_collision),
`ifdef COLLISION_SCAN_HIT_INDEX_EN
    .ground_idx   (ground_idx),
    .ground_vld   (ground_vld),
`endif
    .hit_count    (hit_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Tile table with one cycle of read latency
  always @(posedge clk) begin
    tile_x  <= XW'(tx_mem[tile_addr]);
    tile_y  <= YW'(ty_mem[tile_addr]);
    tile_en <= en_mem[tile_addr];
  end

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference: apply the side rules to every enabled tile with plain integers
  function automatic exp_t ref_scan(input int xs, input int ys);
    exp_t e;
    e.flags = '0; e.cnt = 0; e.gidx = 0; e.gvld = 0; e.cyc = 0;
    for (int i = 0; i < N; i++) begin
      int tx, ty;
      bit h, v, fd, fu, fr, fl;
      if (!en_mem[i]) continue;
      tx = tx_mem[i]; ty = ty_mem[i];
      h  = (xs + DEF_SPR_W - DEF_INSET_R > tx) && (xs + DEF_INSET_L < tx + DEF_TILE_W);
      v  = (ys + DEF_SIDE_OFS <= ty + DEF_TILE_H) && (ys + DEF_SPR_H - 1 >= ty);
      fd = h && (ys + DEF_SPR_H >= ty) && (ys + DEF_SPR_H + DEF_FOOT <= ty + DEF_TILE_H);
      fu = h && (ys >= ty) && (ys <= ty + DEF_TILE_H);
      fr = v && (xs + DEF_SPR_W - DEF_SIDE_OFS >= tx) && (xs + DEF_SPR_W - DEF_SIDE_OFS <= tx + DEF_TILE_W);
      fl = v && (xs >= tx) && (xs <= tx + DEF_TILE_W);
      e.flags |= {fl, fr, fu, fd};
      if (fd || fu || fr || fl) e.cnt++;
      if (fd && !e.gvld) begin e.gidx = i; e.gvld = 1; end
    end
    return e;
  endfunction

  // Monitor: scoreboard pop on done, plus busy and address-walk tracking
  always @(negedge clk) begin
    check("busy", int'(busy), int'(cyc >= busy_lo && cyc <= busy_hi));
    if (cyc >= addr_lo && cyc <= addr_hi) check("tile_addr", int'(tile_addr), cyc - addr_lo);
    if (done) begin
      if (sb.size() == 0) begin
        check("done_spurious", int'(done), 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("done_cycle", cyc, e.cyc);
        check("is_collision", int'(is_collision), int'(e.flags));
        check("hit_count", int'(hit_count), e.cnt);
`ifdef COLLISION_SCAN_HIT_INDEX_EN
        check("ground_idx", int'(ground_idx), e.gidx);
        check("ground_vld", int'(ground_vld), int'(e.gvld));
`endif
        prev_done = last_done;
        last_done = cyc;
      end
    end
  end

  task automatic fill_far();
    for (int i = 0; i < N; i++) begin
      tx_mem[i] = 600; ty_mem[i] = 400; en_mem[i] = 1'b1;
    end
  endtask

  // Drive start in the current cycle; returns at the following negedge
  task automatic issue_start(input int xs, input int ys, output int s0);
    exp_t e;
    x_sprite = XW'(xs);
    y_sprite = YW'(ys);
    start    = 1'b1;
    s0       = cyc;
    e        = ref_scan(xs, ys);
    e.cyc    = s0 + N + 2;
    sb.push_back(e);
    busy_lo = s0 + 1; busy_hi = s0 + N + 1;
    addr_lo = s0 + 1; addr_hi = s0 + N;
    @(negedge clk);
    start    = 1'b0;
    x_sprite = XW'($urandom);
    y_sprite = YW'($urandom);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", sb.size(), 0);
  endtask

  task automatic scan(input int xs, input int ys);
    int s0;
    @(negedge clk);
    issue_start(xs, ys, s0);
    wait_drain();
  endtask

  initial begin
    int s0;
    fill_far();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_coll", int'(is_collision), 0);
    check("rst_hits", int'(hit_count), 0);
    check("rst_done", int'(done), 0);
    check("rst_addr", int'(tile_addr), 0);

    // Directed geometry cases
    fill_far(); tx_mem[0] = 110; ty_mem[0] = 141;
    scan(100, 100);
    check("dir_down", int'(is_collision), 4'b0001);
    fill_far(); tx_mem[3] = 100; ty_mem[3] = 80;
    scan(100, 100);
    check("dir_up_left", int'(is_collision), 4'b1010);
    fill_far(); tx_mem[15] = 1010; ty_mem[15] = 100;
    scan(990, 100);
    check("dir_no_wrap", int'(is_collision), 4'b0110);
    fill_far();
    tx_mem[0] = 110; ty_mem[0] = 141;
    tx_mem[5] = 110; ty_mem[5] = 141; en_mem[5] = 1'b0;
    scan(100, 100);
    check("dir_disabled_tile", int'(hit_count), 1);
    repeat (5) @(negedge clk);
    check("result_hold", int'(is_collision), 4'b0001);

    // Randomized tables clustered around the sprite
    for (int t = 0; t < 30; t++) begin
      int xs, ys;
      xs = $urandom_range(0, 1023);
      ys = $urandom_range(0, 511);
      for (int i = 0; i < N; i++) begin
        int tx, ty;
        tx = xs + $urandom_range(0, 120) - 60;
        ty = ys + $urandom_range(0, 120) - 60;
        tx_mem[i] = (tx < 0) ? 0 : (tx > 1023) ? 1023 : tx;
        ty_mem[i] = (ty < 0) ? 0 : (ty > 511) ? 511 : ty;
        en_mem[i] = ($urandom_range(0, 3) != 0);
      end
      scan(xs, ys);
    end

    // Reset in cycle 4 of a scan: no done, everything cleared
    fill_far(); tx_mem[2] = 110; ty_mem[2] = 141;
    scan(100, 100);
    @(negedge clk);
    issue_start(100, 100, s0);
    while (cyc < s0 + 4) @(negedge clk);
    rst = 1'b1;
    busy_hi = cyc; addr_hi = cyc;
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    check("midrst_coll", int'(is_collision), 0);
    check("midrst_hits", int'(hit_count), 0);
    check("midrst_addr", int'(tile_addr), 0);
    repeat (N + 5) @(negedge clk);

    // start and rst together: reset wins, no scan begins
    rst = 1'b1; start = 1'b1;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    check("rst_wins_busy", int'(busy), 0);
    repeat (N + 5) @(negedge clk);

    // start while busy is ignored: exactly one done
    @(negedge clk);
    issue_start(100, 100, s0);
    while (cyc < s0 + 3) @(negedge clk);
    start = 1'b1; x_sprite = 10'd500;
    @(negedge clk);
    start = 1'b0;
    wait_drain();
    repeat (N + 8) @(negedge clk);

    // Back-to-back: second start in the IDLE-return cycle
    fill_far(); tx_mem[7] = 100; ty_mem[7] = 80;
    @(negedge clk);
    issue_start(100, 100, s0);
    while (cyc < s0 + N + 3) @(negedge clk);
    issue_start(990, 100, s0);
    wait_drain();
    check("b2b_gap", last_done - prev_done, N + 3);
    repeat (4) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/collision_scan.md
# collision_scan

Collision scanner for the player sprite against a table of up to `N_TILES` ground tiles. The single fixed-tile comparator is replaced by one shared comparator that walks a tile table over a read port. It sits between the sprite position registers and the movement/physics logic. On each `start` pulse it returns four accumulated side flags (down, up, right, left), the number of tiles hit, and a one-cycle `done`.

## Interface
Parameters:
- `N_TILES`, 16: number of table entries scanned, ≥1
- `XW`, 10: x coordinate width
- `YW`, 9: y coordinate width
- `SPR_W`, 47 / `SPR_H`, 41: sprite width and height
- `TILE_W`, 25 / `TILE_H`, 24: tile width and height
- `INSET_L`, 12 / `INSET_R`, 17: horizontal insets for the up/down overlap test
- `SIDE_OFS`, 2: side-probe offset
- `FOOT`, 4: depth of the down-probe band

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high.
- `start` in 1: request a scan. Accepted only in IDLE.
- `x_sprite` in XW, `y_sprite` in YW: sprite top-left position. Captured when `start` is accepted.
- `tile_addr` out clog2(N_TILES): tile table read address.
- `tile_x` in XW, `tile_y` in YW, `tile_en` in 1: table read data. Valid one cycle after `tile_addr`.
- `busy` out 1: high from the cycle after `start` acceptance through the `done` cycle, exclusive.
- `done` out 1: one-cycle pulse when the result registers update.
- `is_collision` out 4: bit0 down, bit1 up, bit2 right, bit3 left.
- `hit_count` out clog2(N_TILES+1): number of enabled tiles with any flag set.

## Operation
- State machine:
  - IDLE -> ISSUE on `start`. The sprite x/y snapshot is taken at this point.
  - ISSUE drives addr 0..N_TILES-1, one per cycle.
  - DRAIN waits one cycle for the last read.
  - DONE lasts one cycle, then returns to IDLE.
- Check stage runs one cycle behind ISSUE. It is active when the pipelined valid bit is set.
- A tile with `tile_en`=0 contributes nothing.
- All comparisons are made at XW+1 / YW+1 bits with zero extension. Sums never wrap.
- Horizontal overlap H: `xs+SPR_W-INSET_R > tx` and `xs+INSET_L < tx+TILE_W`.
- Down flag: H, `ys+SPR_H >= ty`, and `ys+SPR_H+FOOT <= ty+TILE_H`.
- Up flag: H, `ys >= ty`, and `ys <= ty+TILE_H`.
- Vertical span V: `ys+SIDE_OFS <= ty+TILE_H` and `ys+SPR_H-1 >= ty`.
- Right flag: V, `xs+SPR_W-SIDE_OFS >= tx`, and `xs+SPR_W-SIDE_OFS <= tx+TILE_W`.
- Left flag: V, `xs >= tx`, and `xs <= tx+TILE_W`.
- Flags are OR-accumulated into shadow registers. The shadow registers clear on `start` acceptance.
- `is_collision` and `hit_count` load from the shadow registers in the DONE cycle only, and hold between scans.
- `start` outside IDLE is ignored and not queued.
- Changes to `x_sprite`/`y_sprite` during a scan have no effect.

## Timing
- Reset values: `is_collision`=0, `hit_count`=0, `done`=0, `busy`=0, `tile_addr`=0, state IDLE.
- `start` at cycle 0:
  - `tile_addr`=k at cycle 1+k.
  - Last check at cycle N_TILES+1.
  - `done` and result update at cycle N_TILES+2.
  - IDLE at N_TILES+3. `start` is accepted again in that cycle.
- `rst` mid-scan: back to IDLE next edge, outputs cleared, no `done`.
- `N_TILES`=1: `done` at cycle 3.
- `start` and `rst` high together: `rst` wins.

## Configuration
- `COLLISION_SCAN_HIT_INDEX_EN` defined:
  - Adds output `ground_idx` (clog2(N_TILES)) and `ground_vld` (1).
  - `ground_idx` holds the lowest index whose down flag fired. Both outputs update with `done` and reset to 0.
- Undefined: the two ports and their logic are absent. All other behaviour is identical.

## Structure
- Package `collision_pkg` holds the default geometry constants (47/41/25/24/12/17/2/4) and the `side_e` bit-position enum: DOWN=0, UP=1, RIGHT=2, LEFT=3.
- Sub-module `collision_box_cmp`: purely combinational, one sprite vs one tile, producing the 4 flags.
- `collision_scan` instantiates `collision_box_cmp` once, together with the FSM, address counter and accumulators.

## Test plan
- Sprite (100,100), single enabled tile (110,141) -> `is_collision`=4'b0001, `hit_count`=1, `done` at cycle N_TILES+2.
- Sprite (100,100), tile (100,80) -> 4'b1010.
- Sprite (990,100), tile (1010,100) -> 4'b0110. Proves no 10-bit wrap on 1035.
- Sixteen tiles: tiles 0 and 5 as in the first scenario, tile 5 with `tile_en`=0, the rest far away -> 4'b0001, `hit_count`=1. With the macro defined, `ground_idx`=0.
- `rst` at cycle 4 of a scan -> no `done` pulse, outputs 0. Also: `start` asserted while busy -> exactly one `done`.
- Back-to-back `start` in the IDLE-return cycle -> second `done` exactly N_TILES+3 cycles after the first.
